// File: rtl/fifo_writer_packer_pkg.sv
// Shared definitions for the byte-stream-to-FIFO packer path.
package fifo_writer_packer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PACK  = 3'd1,
    FLUSH = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } packer_state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LANE_W         = 8;
  localparam int unsigned WORD_W         = BYTES_PER_WORD * LANE_W;

  localparam logic [LANE_W-1:0] PAD_BYTE_DEFAULT = 8'h00;

  // Replace every lane at or above first_pad with the pad value.
  function automatic logic [WORD_W-1:0] pad_word(
    input logic [WORD_W-1:0] word,
    input logic [1:0]        first_pad,
    input logic [LANE_W-1:0] pad
  );
    logic [WORD_W-1:0] res;
    res = word;
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      if (2'(k) >= first_pad) res[k*LANE_W +: LANE_W] = pad;
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_writer_packer_word_hold_reg.sv
// Single-entry holding register between the packer and the FIFO write port.
module word_hold_reg
  import fifo_writer_packer_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              fifo_full,
  output logic              pending,
  output logic              wr_en,
  output logic [WORD_W-1:0] din
);

  logic [WORD_W-1:0] word_q;

  // A word leaves whenever the FIFO has room; a reset cycle never writes.
  assign wr_en = pending && !fifo_full && !RESET;
  assign din   = word_q;

  // Load wins over write so a word can be replaced in the cycle it drains.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pending <= 1'b0;
      word_q  <= '0;
    end else if (load) begin
      pending <= 1'b1;
      word_q  <= load_data;
    end else if (wr_en) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_writer_packer.sv
// Packs a valid/ready byte stream into little-endian 32-bit FIFO words,
// pads a partial last word, and pulses o_Done once the FIFO has taken it.
// Optional FIFO_WRITER_PACKER_CHECKSUM_EN adds a 16-bit byte-sum output.
module fifo_writer_packer
  import fifo_writer_packer_pkg::*;
#(
  parameter logic [7:0]  PAD_BYTE = PAD_BYTE_DEFAULT,
  parameter int unsigned LEN_W    = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_Write_Request,
  input  logic [LEN_W-1:0]  i_RCC_BYTE_LENGTH,
  input  logic [7:0]        i_serialized_input,
  input  logic              i_serialized_input_valid,
  output logic              o_serialized_input_ready,
  input  logic              i_FIFO_full,
  output logic              o_FIFO_wr_en,
  output logic [31:0]       o_FIFO_din,
  output logic [1:0]        o_Serialize_Counter,
  output logic [LEN_W-1:0]  o_Bytes_Counter,
  output logic [LEN_W-3:0]  o_Words_Written,
  output logic              o_Busy,
  output logic              o_Done
`ifdef FIFO_WRITER_PACKER_CHECKSUM_EN
  ,
  output logic [15:0]       o_Checksum
`endif
);

  packer_state_e     state;
  logic [LEN_W-1:0]  len_q;
  logic [WORD_W-1:0] shift_q;

  logic              ready_c;
  logic              accept_c;
  logic              last_byte_c;
  logic              drain_ok_c;
  logic              hold_load_c;
  logic [WORD_W-1:0] merged_c;
  logic [WORD_W-1:0] padded_c;
  logic [WORD_W-1:0] hold_data_c;
  logic [LEN_W-1:0]  bytes_inc_c;
  logic              pending;

  // Single pending-word stage feeding the FIFO write port.
  word_hold_reg u_hold (
    .CLK       (CLK),
    .RESET     (RESET),
    .load      (hold_load_c),
    .load_data (hold_data_c),
    .fifo_full (i_FIFO_full),
    .pending   (pending),
    .wr_en     (o_FIFO_wr_en),
    .din       (o_FIFO_din)
  );

  assign o_serialized_input_ready = ready_c;

  // Handshake, lane merge and holding-register load selection.
  always_comb begin
    ready_c     = (state == PACK) &&
                  !((o_Serialize_Counter == 2'd3) && pending && i_FIFO_full);
    accept_c    = ready_c && i_serialized_input_valid;
    drain_ok_c  = !pending || o_FIFO_wr_en;
    bytes_inc_c = o_Bytes_Counter + LEN_W'(1);
    last_byte_c = accept_c && (bytes_inc_c == len_q);
    merged_c    = shift_q;
    merged_c[{o_Serialize_Counter, 3'b000} +: LANE_W] = i_serialized_input;
    padded_c    = pad_word(shift_q, o_Serialize_Counter, PAD_BYTE);
    hold_load_c = 1'b0;
    hold_data_c = merged_c;
    if (accept_c && (o_Serialize_Counter == 2'd3)) begin
      hold_load_c = 1'b1;
    end else if ((state == FLUSH) && drain_ok_c) begin
      hold_load_c = 1'b1;
      hold_data_c = padded_c;
    end
  end

  // Transfer FSM with its counters and registered status outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state               <= IDLE;
      len_q               <= '0;
      shift_q             <= '0;
      o_Serialize_Counter <= '0;
      o_Bytes_Counter     <= '0;
      o_Words_Written     <= '0;
      o_Busy              <= 1'b0;
      o_Done              <= 1'b0;
    end else begin
      o_Done <= 1'b0;
      if (o_FIFO_wr_en) o_Words_Written <= o_Words_Written + (LEN_W-2)'(1);
      case (state)
        IDLE: begin
          if (i_Write_Request) begin
            len_q               <= i_RCC_BYTE_LENGTH;
            shift_q             <= '0;
            o_Serialize_Counter <= '0;
            o_Bytes_Counter     <= '0;
            o_Words_Written     <= '0;
            o_Busy              <= 1'b1;
            if (i_RCC_BYTE_LENGTH == '0) begin
              state  <= DONE;
              o_Done <= 1'b1;
            end else begin
              state <= PACK;
            end
          end
        end
        PACK: begin
          if (accept_c) begin
            shift_q             <= merged_c;
            o_Serialize_Counter <= o_Serialize_Counter + 2'd1;
            o_Bytes_Counter     <= bytes_inc_c;
            if (last_byte_c) begin
              state <= (o_Serialize_Counter == 2'd3) ? DRAIN : FLUSH;
            end
          end
        end
        FLUSH: begin
          if (drain_ok_c) begin
            shift_q             <= padded_c;
            o_Serialize_Counter <= '0;
            state               <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_ok_c) begin
            state  <= DONE;
            o_Done <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          o_Busy <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          o_Busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_WRITER_PACKER_CHECKSUM_EN
  // Running sum of accepted bytes; pad lanes never pass through accept.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      o_Checksum <= '0;
    end else if ((state == IDLE) && i_Write_Request) begin
      o_Checksum <= '0;
    end else if (accept_c) begin
      o_Checksum <= o_Checksum + 16'(i_serialized_input);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_writer_packer.sv
// Directed bench for fifo_writer_packer (instantiated with PAD_BYTE=8'hAA).
module tb_fifo_writer_packer;

  localparam int unsigned LEN_W = 16;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              i_Write_Request;
  logic [LEN_W-1:0]  i_RCC_BYTE_LENGTH;
  logic [7:0]        i_serialized_input;
  logic              i_serialized_input_valid;
  logic              o_serialized_input_ready;
  logic              i_FIFO_full;
  logic              o_FIFO_wr_en;
  logic [31:0]       o_FIFO_din;
  logic [1:0]        o_Serialize_Counter;
  logic [LEN_W-1:0]  o_Bytes_Counter;
  logic [LEN_W-3:0]  o_Words_Written;
  logic              o_Busy;
  logic              o_Done;
`ifdef FIFO_WRITER_PACKER_CHECKSUM_EN
  logic [15:0]       o_Checksum;
`endif

  fifo_writer_packer #(.PAD_BYTE(8'hAA), .LEN_W(LEN_W)) dut (
    .CLK                      (CLK),
    .RESET                    (RESET),
    .i_Write_Request          (i_Write_Request),
    .i_RCC_BYTE_LENGTH        (i_RCC_BYTE_LENGTH),
    .i_serialized_input       (i_serialized_input),
    .i_serialized_input_valid (i_serialized_input_valid),
    .o_serialized_input_ready (o_serialized_input_ready),
    .i_FIFO_full              (i_FIFO_full),
    .o_FIFO_wr_en             (o_FIFO_wr_en),
    .o_FIFO_din               (o_FIFO_din),
    .o_Serialize_Counter      (o_Serialize_Counter),
    .o_Bytes_Counter          (o_Bytes_Counter),
    .o_Words_Written          (o_Words_Written),
    .o_Busy                   (o_Busy),
    .o_Done                   (o_Done)
`ifdef FIFO_WRITER_PACKER_CHECKSUM_EN
    ,
    .o_Checksum               (o_Checksum)
`endif
  );

  always #5 CLK = ~CLK;

  int tests_run    = 0;
  int tests_failed = 0;

  // Stimulus bytes and per-transfer observations.
  logic [7:0]       stim[16];
  int               n_bytes;
  logic [31:0]      wr_log[$];
  int               wr_cyc[$];
  int               done_cnt, done_cyc, rdy_cnt, stall_cnt, stall_bad, full_wr;
  logic             busy_after;
  logic [LEN_W-1:0] bytes_at_done;
  logic [LEN_W-3:0] words_at_done;
  logic [15:0]      cks_at_done;

  // Runs one transfer; cycle 0 is the first cycle after the start request.
  task automatic xfer(input int len, input int full_from, input int full_cnt);
    int idx;
    wr_log.delete();
    wr_cyc.delete();
    done_cnt = 0; done_cyc = -1; rdy_cnt = 0; stall_cnt = 0; stall_bad = 0;
    full_wr = 0; busy_after = 1'bx; bytes_at_done = 'x; words_at_done = 'x;
    cks_at_done = 'x;
    idx = 0;
    @(negedge CLK);
    i_Write_Request   = 1'b1;
    i_RCC_BYTE_LENGTH = LEN_W'(len);
    @(posedge CLK);
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge CLK);
      i_Write_Request          = 1'b0;
      i_FIFO_full              = (cyc >= full_from) && (cyc < full_from + full_cnt);
      i_serialized_input_valid = (idx < n_bytes);
      i_serialized_input       = (idx < n_bytes) ? stim[idx] : 8'h00;
      #1;
      if (o_serialized_input_ready) rdy_cnt++;
      if (i_serialized_input_valid && !o_serialized_input_ready) begin
        stall_cnt++;
        if (!((o_Serialize_Counter == 2'd3) && i_FIFO_full)) stall_bad++;
      end
      if (o_FIFO_wr_en) begin
        wr_log.push_back(o_FIFO_din);
        wr_cyc.push_back(cyc);
        if (i_FIFO_full) full_wr++;
      end
      if (o_Done) begin
        done_cnt++;
        done_cyc      = cyc;
        bytes_at_done = o_Bytes_Counter;
        words_at_done = o_Words_Written;
`ifdef FIFO_WRITER_PACKER_CHECKSUM_EN
        cks_at_done   = o_Checksum;
`endif
      end
      if (i_serialized_input_valid && o_serialized_input_ready) idx++;
      if ((done_cnt > 0) && (cyc > done_cyc)) begin
        busy_after = o_Busy;
        break;
      end
    end
    i_serialized_input_valid = 1'b0;
    i_FIFO_full              = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    i_Write_Request = 1'b0; i_RCC_BYTE_LENGTH = '0; i_serialized_input = '0;
    i_serialized_input_valid = 1'b0; i_FIFO_full = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    tests_run++;
    if ({o_FIFO_wr_en, o_serialized_input_ready, o_Busy, o_Done} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 0000",
               {o_FIFO_wr_en, o_serialized_input_ready, o_Busy, o_Done});
    end
    tests_run++;
    if ({o_FIFO_din, o_Serialize_Counter, o_Bytes_Counter, o_Words_Written} !== '0) begin
      tests_failed++;
      $display("FAIL reset_values: din %h ser %0d bytes %0d words %0d expected all 0",
               o_FIFO_din, o_Serialize_Counter, o_Bytes_Counter, o_Words_Written);
    end
    RESET = 1'b0;
  endtask

  task automatic test_full_words();
    for (int i = 0; i < 8; i++) stim[i] = 8'(i + 1);
    n_bytes = 8;
    xfer(8, 1000, 0);
    tests_run++;
    if (done_cnt !== 1) begin
      tests_failed++; $display("FAIL len8_done_count: got %0d expected 1", done_cnt);
    end
    tests_run++;
    if (wr_log.size() !== 2) begin
      tests_failed++; $display("FAIL len8_write_count: got %0d expected 2", wr_log.size());
    end else begin
      tests_run++;
      if (wr_log[0] !== 32'h04030201 || wr_log[1] !== 32'h08070605) begin
        tests_failed++;
        $display("FAIL len8_data: got %h %h expected 04030201 08070605", wr_log[0], wr_log[1]);
      end
      tests_run++;
      if (done_cyc - wr_cyc[1] !== 1) begin
        tests_failed++;
        $display("FAIL len8_done_timing: got %0d cycles after write expected 1",
                 done_cyc - wr_cyc[1]);
      end
    end
    tests_run++;
    if (words_at_done !== 14'd2 || bytes_at_done !== 16'd8) begin
      tests_failed++;
      $display("FAIL len8_counters: words %0d bytes %0d expected 2 8", words_at_done, bytes_at_done);
    end
    tests_run++;
    if (busy_after !== 1'b0) begin
      tests_failed++; $display("FAIL len8_idle_after: busy %b expected 0", busy_after);
    end
  endtask

  task automatic test_pad_flush();
    for (int i = 0; i < 6; i++) stim[i] = 8'h11 + 8'(i);
    n_bytes = 6;
    xfer(6, 1000, 0);
    tests_run++;
    if (wr_log.size() !== 2) begin
      tests_failed++; $display("FAIL len6_write_count: got %0d expected 2", wr_log.size());
    end else begin
      tests_run++;
      if (wr_log[0] !== 32'h14131211 || wr_log[1] !== 32'hAAAA1615) begin
        tests_failed++;
        $display("FAIL len6_data: got %h %h expected 14131211 AAAA1615", wr_log[0], wr_log[1]);
      end
    end
    tests_run++;
    if (done_cnt !== 1 || bytes_at_done !== 16'd6 || words_at_done !== 14'd2) begin
      tests_failed++;
      $display("FAIL len6_counters: done %0d bytes %0d words %0d expected 1 6 2",
               done_cnt, bytes_at_done, words_at_done);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 12; i++) stim[i] = 8'h21 + 8'(i);
    n_bytes = 12;
    xfer(12, 3, 10);
    tests_run++;
    if (wr_log.size() !== 3) begin
      tests_failed++; $display("FAIL full_write_count: got %0d expected 3", wr_log.size());
    end else begin
      tests_run++;
      if (wr_log[0] !== 32'h24232221 || wr_log[1] !== 32'h28272625 ||
          wr_log[2] !== 32'h2C2B2A29) begin
        tests_failed++;
        $display("FAIL full_data: got %h %h %h expected 24232221 28272625 2C2B2A29",
                 wr_log[0], wr_log[1], wr_log[2]);
      end
    end
    tests_run++;
    if (full_wr !== 0) begin
      tests_failed++; $display("FAIL full_write_while_full: got %0d expected 0", full_wr);
    end
    tests_run++;
    if (stall_cnt !== 6 || stall_bad !== 0) begin
      tests_failed++;
      $display("FAIL full_ready_drops: stalls %0d bad %0d expected 6 0", stall_cnt, stall_bad);
    end
    tests_run++;
    if (done_cnt !== 1 || words_at_done !== 14'd3) begin
      tests_failed++;
      $display("FAIL full_done: done %0d words %0d expected 1 3", done_cnt, words_at_done);
    end
  endtask

  task automatic test_zero_length();
    n_bytes = 0;
    xfer(0, 1000, 0);
    tests_run++;
    if (done_cnt !== 1 || done_cyc !== 0) begin
      tests_failed++;
      $display("FAIL len0_done: count %0d cycle %0d expected 1 0", done_cnt, done_cyc);
    end
    tests_run++;
    if (wr_log.size() !== 0 || rdy_cnt !== 0) begin
      tests_failed++;
      $display("FAIL len0_quiet: writes %0d ready_cycles %0d expected 0 0",
               wr_log.size(), rdy_cnt);
    end
    tests_run++;
    if (busy_after !== 1'b0) begin
      tests_failed++; $display("FAIL len0_idle_after: busy %b expected 0", busy_after);
    end
  endtask

  task automatic test_reset_mid_transfer();
    int idx;
    int post_wr;
    idx = 0;
    post_wr = 0;
    for (int i = 0; i < 8; i++) stim[i] = 8'(i + 1);
    @(negedge CLK);
    i_Write_Request = 1'b1; i_RCC_BYTE_LENGTH = 16'd8;
    @(posedge CLK);
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge CLK);
      i_Write_Request = 1'b0;
      i_serialized_input_valid = 1'b1;
      i_serialized_input = stim[idx];
      #1;
      if (o_serialized_input_ready) idx++;
    end
    tests_run++;
    if (idx !== 5) begin
      tests_failed++; $display("FAIL rst_mid_progress: accepted %0d expected 5", idx);
    end
    @(negedge CLK);
    RESET = 1'b1;
    i_serialized_input = stim[5];
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    i_serialized_input_valid = 1'b0;
    #1;
    tests_run++;
    if ({o_FIFO_wr_en, o_serialized_input_ready, o_Busy, o_Done} !== 4'b0000 ||
        {o_FIFO_din, o_Serialize_Counter, o_Bytes_Counter, o_Words_Written} !== '0) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs: flags %b din %h ser %0d bytes %0d words %0d expected all 0",
               {o_FIFO_wr_en, o_serialized_input_ready, o_Busy, o_Done},
               o_FIFO_din, o_Serialize_Counter, o_Bytes_Counter, o_Words_Written);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      #1;
      if (o_FIFO_wr_en || o_Busy) post_wr++;
    end
    tests_run++;
    if (post_wr !== 0) begin
      tests_failed++; $display("FAIL rst_mid_quiet: active cycles %0d expected 0", post_wr);
    end
    for (int i = 0; i < 4; i++) stim[i] = 8'hA0 + 8'(i);
    n_bytes = 4;
    xfer(4, 1000, 0);
    tests_run++;
    if (wr_log.size() !== 1) begin
      tests_failed++; $display("FAIL rst_after_count: got %0d expected 1", wr_log.size());
    end else begin
      tests_run++;
      if (wr_log[0] !== 32'hA3A2A1A0) begin
        tests_failed++; $display("FAIL rst_after_data: got %h expected A3A2A1A0", wr_log[0]);
      end
    end
    tests_run++;
    if (done_cnt !== 1 || words_at_done !== 14'd1 || bytes_at_done !== 16'd4) begin
      tests_failed++;
      $display("FAIL rst_after_done: done %0d words %0d bytes %0d expected 1 1 4",
               done_cnt, words_at_done, bytes_at_done);
    end
  endtask

`ifdef FIFO_WRITER_PACKER_CHECKSUM_EN
  task automatic test_checksum();
    stim[0] = 8'hFF; stim[1] = 8'hFF; stim[2] = 8'h01;
    n_bytes = 3;
    xfer(3, 1000, 0);
    tests_run++;
    if (done_cnt !== 1 || cks_at_done !== 16'h01FF) begin
      tests_failed++;
      $display("FAIL checksum: done %0d sum %h expected 1 01FF", done_cnt, cks_at_done);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_words();
    test_pad_flush();
    test_backpressure();
    test_zero_length();
    test_reset_mid_transfer();
`ifdef FIFO_WRITER_PACKER_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
